cbus_sram_responder: RTL and testbench



---
 rtl/cbus_sram_responder.sv | 177 +++++++++++++++++
 tb/tb_cbus_sram_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cbus_sram_responder.sv
// Responder end of the simplified burst cache bus, backed by a 64-bit SRAM array.
// Serves FIXED/INCR/WRAP single and burst transfers with byte-strobed writes.
package cbus_pkg;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_sram_responder
    import cbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    // state     | meaning
    // S_IDLE    | waiting for creq.valid; request fields sampled here only
    // S_RD_PREP | SRAM read of beat 0 in flight
    // S_RD_BEAT | read beat presented; next beat's word fetched in parallel
    // S_WR_BEAT | write beat accepted at each edge
    // S_DONE    | one dead cycle before returning to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_PREP,
        S_RD_BEAT,
        S_WR_BEAT,
        S_DONE
    } state_e;

    logic [63:0] mem [MEM_WORDS];

    state_e      state_q, state_d;
    logic [2:0]  size_q, size_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  i_q, i_d;
    logic        ready_q, ready_d;
    logic        last_q, last_d;
    logic [63:0] data_q, data_d;

    logic [63:0]      rd_addr;
    logic [63:0]      wr_addr;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;

    // WRAP keeps the upper address bits and wraps the offset inside the
    // naturally aligned block of (len+1)*step bytes.
    function automatic logic [63:0] beat_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst,
                                              input logic [7:0]  i);
        logic [63:0] off;
        logic [63:0] mask;
        logic [63:0] res;
        off  = {56'd0, i} << size;
        mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_FIXED: res = addr;
            BURST_WRAP:  res = (addr & ~mask) | ((addr + off) & mask);
            default:     res = addr + off;
        endcase
        return res;
    endfunction

    function automatic logic in_range(input logic [63:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 3) < 64'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
        return IDX_W'((a - BASE_ADDR) >> 3);
    endfunction

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: begin
                if (creq.valid) begin
                    size_d  = creq.size;
                    addr_d  = creq.addr;
                    len_d   = creq.len;
                    burst_d = creq.burst;
                    i_d     = 8'd0;
                    state_d = creq.is_write ? S_WR_BEAT : S_RD_PREP;
                end
            end
            S_RD_PREP: state_d = S_RD_BEAT;
            S_RD_BEAT, S_WR_BEAT: begin
                if (i_q == len_q) state_d = S_DONE;
                else              i_d     = i_q + 8'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from next-state values so they register cleanly.
        rd_addr = beat_addr(addr_d, size_d, len_d, burst_d, i_d);
        ready_d = (state_d == S_RD_BEAT) || (state_d == S_WR_BEAT);
        last_d  = ready_d && (i_d == len_d);
        data_d  = 64'd0;
        if (state_d == S_RD_BEAT && in_range(rd_addr)) begin
            data_d = mem[word_idx(rd_addr)];
        end

        wr_addr = beat_addr(addr_q, size_q, len_q, burst_q, i_q);
        wr_en   = (state_q == S_WR_BEAT) && in_range(wr_addr);
        wr_idx  = word_idx(wr_addr);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            size_q  <= 3'd0;
            addr_q  <= 64'd0;
            len_q   <= 8'd0;
            burst_q <= 2'd0;
            i_q     <= 8'd0;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            i_q     <= i_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    // Array is not reset; writes are gated by the async-reset state register.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 8; k++) begin
                if (creq.strobe[k]) mem[wr_idx][8*k +: 8] <= creq.data[8*k +: 8];
            end
        end
    end

    assign cresp.ready = ready_q;
    assign cresp.last  = last_q;
    assign cresp.data  = data_q;

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder: handshake timing, burst ordering,
// strobes, out-of-range accesses and reset in the middle of a burst.
module tb_cbus_sram_responder;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int total = 0;
    int bad   = 0;

    logic [63:0] ex [16];
    logic [63:0] wd [16];

    cbus_sram_responder #(
        .MEM_WORDS(4096),
        .BASE_ADDR(64'h0000_0000_8000_0000)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .creq  (creq),
        .cresp (cresp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] addr, input logic [2:0] size, input logic [7:0] len,
                      input logic [1:0] burst, input logic [7:0] strb);
        creq          = '0;
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.size     = size;
        creq.addr     = addr;
        creq.len      = len;
        creq.burst    = burst;
        creq.strobe   = strb;
        creq.data     = wd[0];
        step();
        for (int b = 0; b <= int'(len); b++) begin
            chk("wr_ready", 64'(cresp.ready), 64'd1);
            chk("wr_last", 64'(cresp.last), 64'(b == int'(len)));
            creq.data = wd[b];
            step();
        end
        creq = '0;
        chk("wr_done_ready", 64'(cresp.ready), 64'd0);
        step();
    endtask

    task automatic rd(input string tag, input logic [63:0] addr, input logic [2:0] size,
                      input logic [7:0] len, input logic [1:0] burst);
        creq       = '0;
        creq.valid = 1'b1;
        creq.size  = size;
        creq.addr  = addr;
        creq.len   = len;
        creq.burst = burst;
        step();
        chk({tag, "_prep_ready"}, 64'(cresp.ready), 64'd0);
        step();
        for (int b = 0; b <= int'(len); b++) begin
            chk({tag, "_ready"}, 64'(cresp.ready), 64'd1);
            chk({tag, "_last"}, 64'(cresp.last), 64'(b == int'(len)));
            chk({tag, "_data"}, cresp.data, ex[b]);
            step();
        end
        creq = '0;
        chk({tag, "_done_ready"}, 64'(cresp.ready), 64'd0);
        chk({tag, "_done_last"}, 64'(cresp.last), 64'd0);
        chk({tag, "_done_data"}, cresp.data, 64'd0);
        step();
    endtask

    initial begin
        creq   = '0;
        resetn = 1'b0;
        step();
        step();
        chk("rst_ready", 64'(cresp.ready), 64'd0);
        chk("rst_last", 64'(cresp.last), 64'd0);
        chk("rst_data", cresp.data, 64'd0);
        resetn = 1'b1;
        step();

        // single write, single read
        wd[0] = 64'hDEAD_BEEF_0123_4567;
        wr(64'h8000_0010, 3'd3, 8'd0, BURST_INCR, 8'hFF);
        ex[0] = 64'hDEAD_BEEF_0123_4567;
        rd("single", 64'h8000_0010, 3'd3, 8'd0, BURST_INCR);

        // INCR burst of 4
        for (int k = 0; k < 4; k++) wd[k] = 64'h10 + 64'(k);
        wr(64'h8000_0000, 3'd3, 8'd3, BURST_INCR, 8'hFF);
        for (int k = 0; k < 4; k++) ex[k] = 64'h10 + 64'(k);
        rd("incr", 64'h8000_0000, 3'd3, 8'd3, BURST_INCR);

        // WRAP burst of 8 starting mid-block
        for (int k = 0; k < 8; k++) wd[k] = 64'h20 + 64'(k);
        wr(64'h8000_0000, 3'd3, 8'd7, BURST_INCR, 8'hFF);
        ex[0] = 64'h25; ex[1] = 64'h26; ex[2] = 64'h27; ex[3] = 64'h20;
        ex[4] = 64'h21; ex[5] = 64'h22; ex[6] = 64'h23; ex[7] = 64'h24;
        rd("wrap", 64'h8000_0028, 3'd3, 8'd7, BURST_WRAP);

        // FIXED burst repeats the same word
        ex[0] = 64'h21; ex[1] = 64'h21; ex[2] = 64'h21;
        rd("fixed", 64'h8000_0008, 3'd3, 8'd2, BURST_FIXED);

        // strobed write, then an all-zero strobe
        wd[0] = 64'h0;
        wr(64'h8000_0040, 3'd3, 8'd0, BURST_INCR, 8'hFF);
        wd[0] = 64'hAAAA_BBBB_CCCC_DDDD;
        wr(64'h8000_0040, 3'd3, 8'd0, BURST_INCR, 8'b0000_1100);
        ex[0] = 64'h0000_0000_CCCC_0000;
        rd("strobe", 64'h8000_0040, 3'd3, 8'd0, BURST_INCR);
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(64'h8000_0040, 3'd3, 8'd0, BURST_INCR, 8'h00);
        rd("strobe0", 64'h8000_0040, 3'd3, 8'd0, BURST_INCR);

        // out of range on both sides
        wd[0] = 64'h5555;
        wr(64'h8000_7FF8, 3'd3, 8'd0, BURST_INCR, 8'hFF);
        ex[0] = 64'h0;
        rd("oor_lo", 64'h7FFF_FFF8, 3'd3, 8'd0, BURST_INCR);
        rd("oor_hi", 64'h8000_8000, 3'd3, 8'd0, BURST_INCR);
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(64'h8000_8000, 3'd3, 8'd0, BURST_INCR, 8'hFF);
        wr(64'h7FFF_FFF8, 3'd3, 8'd0, BURST_INCR, 8'hFF);
        ex[0] = 64'h20;
        rd("oor_w0", 64'h8000_0000, 3'd3, 8'd0, BURST_INCR);
        ex[0] = 64'h5555;
        rd("oor_wlast", 64'h8000_7FF8, 3'd3, 8'd0, BURST_INCR);

        // reset during the third beat of an 8-beat INCR read
        creq       = '0;
        creq.valid = 1'b1;
        creq.size  = 3'd3;
        creq.addr  = 64'h8000_0000;
        creq.len   = 8'd7;
        creq.burst = BURST_INCR;
        step();
        step();
        step();
        step();
        chk("mid_beat3_data", cresp.data, 64'h22);
        resetn = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(cresp.ready), 64'd0);
        chk("mid_rst_last", 64'(cresp.last), 64'd0);
        chk("mid_rst_data", cresp.data, 64'd0);
        creq = '0;
        step();
        step();
        resetn = 1'b1;
        step();
        ex[0] = 64'h23;
        rd("after_rst", 64'h8000_0018, 3'd3, 8'd0, BURST_INCR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
